// File: rtl/fadd_round_pack_if.sv
// Handshake and data bundle for the FP-add round/pack output stage.
// slave = the stage itself, master = the upstream/downstream driver.
interface fadd_round_pack_if #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
);
    logic                    in_valid;
    logic                    in_ready;
    logic                    sign_in;
    logic [FRAC_W+1:0]       m_in;
    logic                    round_in;
    logic [EXP_W-1:0]        exp_in;
    logic                    out_valid;
    logic                    out_ready;
    logic [EXP_W+FRAC_W:0]   out_result;
    logic                    out_inexact;
    logic                    out_overflow;
    logic                    flags_clr;
    logic [1:0]              sticky_flags;

    modport slave (
        input  in_valid, sign_in, m_in, round_in, exp_in, out_ready, flags_clr,
        output in_ready, out_valid, out_result, out_inexact, out_overflow, sticky_flags
    );

    modport master (
        output in_valid, sign_in, m_in, round_in, exp_in, out_ready, flags_clr,
        input  in_ready, out_valid, out_result, out_inexact, out_overflow, sticky_flags
    );
endinterface

// File: rtl/fadd_round_pack.sv
// FP adder output stage: round-to-nearest-even (S1), carry/overflow fix-up and pack (S2).
// Optional accumulated {overflow, inexact} register: define FADD_STICKY_FLAGS_EN.
module fadd_round_pack #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
) (
    input  logic               clk,
    input  logic               rst_n,
    fadd_round_pack_if.slave   bus
);
    localparam int RES_W = 1 + EXP_W + FRAC_W;

    logic adv1, adv2, in_hs, out_hs;

    logic               s1_valid_q;
    logic               s1_sign_q, s1_zero_q, s1_inexact_q;
    logic [EXP_W-1:0]   s1_exp_q;
    logic [FRAC_W:0]    s1_frac_q;

    logic               s2_valid_q;
    logic [RES_W-1:0]   res_q;
    logic               inexact_q, overflow_q;

    // Global stall: a stage moves only if the stage below it is free or draining.
    assign adv2   = !s2_valid_q | bus.out_ready;
    assign adv1   = !s1_valid_q | adv2;
    assign in_hs  = bus.in_valid & adv1;
    assign out_hs = s2_valid_q & bus.out_ready;

    assign bus.in_ready     = adv1;
    assign bus.out_valid    = s2_valid_q;
    assign bus.out_result   = res_q;
    assign bus.out_inexact  = inexact_q;
    assign bus.out_overflow = overflow_q;

    logic            g_d, lsb_d, inc_d, zero_d;
    logic [FRAC_W:0] frac_r_d;

    always_comb begin
        g_d      = bus.m_in[0];
        lsb_d    = bus.m_in[1];
        inc_d    = g_d & (bus.round_in | lsb_d);
        frac_r_d = {1'b0, bus.m_in[FRAC_W:1]} + (FRAC_W+1)'(inc_d);
        zero_d   = (bus.m_in == '0) && (bus.exp_in == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            s1_sign_q    <= 1'b0;
            s1_zero_q    <= 1'b0;
            s1_inexact_q <= 1'b0;
            s1_exp_q     <= '0;
            s1_frac_q    <= '0;
        end else begin
            if (adv1)
                s1_valid_q <= bus.in_valid;
            if (in_hs) begin
                s1_sign_q    <= bus.sign_in;
                s1_zero_q    <= zero_d;
                s1_inexact_q <= g_d | bus.round_in;
                s1_exp_q     <= bus.exp_in;
                s1_frac_q    <= frac_r_d;
            end
        end
    end

    logic [EXP_W:0]     exp_n_d;
    logic [FRAC_W-1:0]  frac_p_d;
    logic               ovf_d;
    logic [RES_W-1:0]   res_d;
    logic               inexact_d, overflow_d;

    always_comb begin
        exp_n_d    = {1'b0, s1_exp_q} + (EXP_W+1)'(s1_frac_q[FRAC_W]);
        frac_p_d   = s1_frac_q[FRAC_W] ? '0 : s1_frac_q[FRAC_W-1:0];
        // An Inf/NaN exponent coming in is saturated to Inf as well.
        ovf_d      = (exp_n_d >= {1'b0, {EXP_W{1'b1}}}) || (s1_exp_q == {EXP_W{1'b1}});
        res_d      = {s1_sign_q, exp_n_d[EXP_W-1:0], frac_p_d};
        inexact_d  = s1_inexact_q;
        overflow_d = 1'b0;
        if (s1_zero_q) begin
            res_d     = '0;
            inexact_d = 1'b0;
        end else if (ovf_d) begin
            res_d      = {s1_sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            res_q      <= '0;
            inexact_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else if (adv2) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                res_q      <= res_d;
                inexact_q  <= inexact_d;
                overflow_q <= overflow_d;
            end
        end
    end

`ifdef FADD_STICKY_FLAGS_EN
    logic [1:0] sticky_q;

    // A clear wins over history but not over the flags of a result leaving this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sticky_q <= 2'b00;
        else if (bus.flags_clr)
            sticky_q <= out_hs ? {overflow_q, inexact_q} : 2'b00;
        else if (out_hs)
            sticky_q <= sticky_q | {overflow_q, inexact_q};
    end

    assign bus.sticky_flags = sticky_q;
`else
    logic unused_flags;
    assign unused_flags     = bus.flags_clr | out_hs;
    assign bus.sticky_flags = 2'b00;
`endif
endmodule

// File: tb/tb_fadd_round_pack.sv
// Bench for fadd_round_pack: directed vector table, backpressure/reset sequences, random scoreboard.
module tb_fadd_round_pack;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fadd_round_pack_if #(.EXP_W(8), .FRAC_W(23)) bus ();
    fadd_round_pack #(.EXP_W(8), .FRAC_W(23)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct { logic [31:0] res; logic inx; logic ovf; } exp_t;
    typedef struct { logic s; logic [24:0] m; logic r; logic [7:0] e; exp_t x; } vec_t;

    exp_t        sbq[$];
    int          checks = 0, errors = 0;
    logic [1:0]  mf = 2'b00;
    logic        last_ohs = 1'b0, last_ihs = 1'b0, hold_v = 1'b0;
    logic [31:0] hold_res = '0;
    exp_t        nox = '{32'h0, 1'b0, 1'b0};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference: round the 23 stored bits on {guard, sticky}, ties to even, then pack.
    function automatic exp_t model(input logic s, input logic [24:0] m, input logic r, input logic [7:0] e);
        exp_t o;
        int frac, ex, inc;
        o.inx = m[0] | r;
        o.ovf = 1'b0;
        if (m == 0 && e == 0) begin
            o.res = 32'h0;
            o.inx = 1'b0;
            return o;
        end
        frac = int'(m >> 1) % (1 << 23);
        inc  = (m[0] && (r || (frac % 2 == 1))) ? 1 : 0;
        frac = frac + inc;
        ex   = int'(e);
        if (frac == (1 << 23)) begin
            frac = 0;
            ex   = ex + 1;
        end
        if (ex >= 255 || e == 8'hFF) begin
            o.res = {s, 8'hFF, 23'h0};
            o.ovf = 1'b1;
        end else begin
            o.res = {s, 8'(ex), 23'(frac)};
        end
        return o;
    endfunction

    task automatic step(input logic iv, input logic s, input logic [24:0] m, input logic r,
                        input logic [7:0] e, input logic ordy, input logic clr,
                        input logic tab, input exp_t tv);
        exp_t ev;
        logic [1:0] nf;
        @(negedge clk);
        chk("sticky", bus.sticky_flags, mf);
        if (hold_v) chk("stall_hold", {bus.out_valid, bus.out_result}, {1'b1, hold_res});
        bus.in_valid  = iv;
        bus.sign_in   = s;
        bus.m_in      = m;
        bus.round_in  = r;
        bus.exp_in    = e;
        bus.out_ready = ordy;
        bus.flags_clr = clr;
        #1;
        last_ohs = bus.out_valid & bus.out_ready;
        last_ihs = iv & bus.in_ready;
        nf = 2'b00;
        if (last_ohs) begin
            if (sbq.size() == 0) begin
                chk("unexpected_out", 1, 0);
            end else begin
                ev = sbq.pop_front();
                chk("result", bus.out_result, ev.res);
                chk("inexact", bus.out_inexact, ev.inx);
                chk("overflow", bus.out_overflow, ev.ovf);
                nf = {ev.ovf, ev.inx};
            end
        end
`ifdef FADD_STICKY_FLAGS_EN
        if (clr) mf = last_ohs ? nf : 2'b00;
        else if (last_ohs) mf = mf | nf;
`endif
        hold_v   = bus.out_valid & !bus.out_ready;
        hold_res = bus.out_result;
        if (last_ihs) sbq.push_back(tab ? tv : model(s, m, r, e));
    endtask

    task automatic idle(input logic ordy, input logic clr);
        step(1'b0, 1'b0, 25'h0, 1'b0, 8'h0, ordy, clr, 1'b0, nox);
    endtask

    task automatic rand_in(output logic s, output logic [24:0] m, output logic r, output logic [7:0] e);
        s = 1'($urandom);
        r = 1'($urandom);
        m = {1'b1, 24'($urandom)};
        e = 8'($urandom_range(1, 253));
        case ($urandom_range(0, 9))
            0: begin m = 25'h0; e = 8'h0; end
            1: e = 8'hFE;
            2: e = 8'hFF;
            3: m = {1'b1, 22'h3FFFFF, 2'($urandom)};
            4: e = 8'h0;
            default: ;
        endcase
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && sbq.size() != 0; k++) idle(1'b1, 1'b0);
        chk("drained", sbq.size(), 0);
    endtask

    vec_t tab[10];
    logic        rs, rr;
    logic [24:0] rm;
    logic [7:0]  re;
    int n, cyc, acc;

    initial begin
        tab[0] = '{1'b0, 25'h1000000, 1'b0, 8'h7F, '{32'h3F800000, 1'b0, 1'b0}};
        tab[1] = '{1'b0, 25'h1000003, 1'b0, 8'h7F, '{32'h3F800002, 1'b1, 1'b0}};
        tab[2] = '{1'b0, 25'h1000001, 1'b0, 8'h7F, '{32'h3F800000, 1'b1, 1'b0}};
        tab[3] = '{1'b0, 25'h1000001, 1'b1, 8'h7F, '{32'h3F800001, 1'b1, 1'b0}};
        tab[4] = '{1'b0, 25'h1FFFFFF, 1'b0, 8'h7F, '{32'h40000000, 1'b1, 1'b0}};
        tab[5] = '{1'b0, 25'h1FFFFFF, 1'b0, 8'hFE, '{32'h7F800000, 1'b1, 1'b1}};
        tab[6] = '{1'b1, 25'h0000000, 1'b0, 8'h00, '{32'h00000000, 1'b0, 1'b0}};
        tab[7] = '{1'b1, 25'h1000000, 1'b0, 8'hFF, '{32'hFF800000, 1'b0, 1'b1}};
        tab[8] = '{1'b1, 25'h0000004, 1'b0, 8'h00, '{32'h80000002, 1'b0, 1'b0}};
        tab[9] = '{1'b1, 25'h1000000, 1'b1, 8'h7F, '{32'hBF800000, 1'b1, 1'b0}};

        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.sign_in = 1'b0; bus.m_in = '0; bus.round_in = 1'b0;
        bus.exp_in = '0; bus.out_ready = 1'b0; bus.flags_clr = 1'b0;
        #12;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_result", bus.out_result, 0);
        chk("rst_flags", {bus.out_inexact, bus.out_overflow, bus.sticky_flags}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("rst_in_ready", bus.in_ready, 1);

        // Directed vectors, one at a time, with latency check
        for (int i = 0; i < 10; i++) begin
            step(1'b1, tab[i].s, tab[i].m, tab[i].r, tab[i].e, 1'b1, 1'b0, 1'b1, tab[i].x);
            n = 0;
            do begin
                idle(1'b1, 1'b0);
                n++;
            end while (!last_ohs && n < 6);
            chk("latency", n, 2);
        end
        idle(1'b1, 1'b0);
`ifdef FADD_STICKY_FLAGS_EN
        chk("sticky_accum", bus.sticky_flags, 2'b11);
`else
        chk("sticky_off", bus.sticky_flags, 2'b00);
`endif
        idle(1'b1, 1'b1);
        idle(1'b1, 1'b0);
        chk("sticky_clr", bus.sticky_flags, 2'b00);

        // Backpressure: 5 back-to-back inputs, out_ready low on cycles 3..6
        cyc = 0; acc = 0;
        while (acc < 5 && cyc < 40) begin
            cyc++;
            rand_in(rs, rm, rr, re);
            step(1'b1, rs, rm, rr, re, !(cyc >= 3 && cyc <= 6), 1'b0, 1'b0, nox);
            if (cyc >= 3 && cyc <= 6) chk("in_ready_full", bus.in_ready, 0);
            if (last_ihs) acc++;
        end
        chk("bp_accepted", acc, 5);
        drain();

        // Random traffic with a mid-stream asynchronous reset
        for (int phase = 0; phase < 2; phase++) begin
            for (int k = 0; k < 150; k++) begin
                rand_in(rs, rm, rr, re);
                step(1'($urandom_range(0, 3) != 0), rs, rm, rr, re,
                     1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 19) == 0), 1'b0, nox);
            end
            if (phase == 0) begin
                #2 rst_n = 1'b0;
                bus.in_valid = 1'b0;
                #1;
                chk("mid_rst_valid", bus.out_valid, 0);
                chk("mid_rst_result", bus.out_result, 0);
                chk("mid_rst_flags", {bus.out_inexact, bus.out_overflow, bus.sticky_flags}, 0);
                sbq.delete();
                mf = 2'b00;
                hold_v = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                #1 chk("mid_rst_in_ready", bus.in_ready, 1);
            end
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fadd_round_pack.md
# fadd_round_pack

Output stage of the floating-point adder/subtractor datapath. Consumes the normalized mantissa, rounding bit and exponent produced by the mantissa add/sub stages. Applies IEEE-754 round-to-nearest-even and handles mantissa carry-out and exponent overflow. Packs sign/exponent/fraction into a single-precision word behind a 2-stage valid/ready pipeline.

## Interface
Parameters:
- EXP_W, 8, exponent width; all-ones exponent (255) is Inf.
- FRAC_W, 23, stored fraction width; m_in width is FRAC_W+2.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset. Single clock domain; reset asserts asynchronously and is released synchronously by the system.
- in_valid  input  1  operand valid.
- in_ready  output  1  stage can accept.
- sign_in  input  1  result sign from the upstream compare.
- m_in  input  FRAC_W+2  normalized mantissa: [24] = leading one, [23:1] = fraction, [0] = guard bit.
- round_in  input  1  sticky/round bit below guard.
- exp_in  input  EXP_W  biased exponent after normalization.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts.
- out_result  output  1+EXP_W+FRAC_W  packed IEEE-754 word {sign, exp, frac}.
- out_inexact  output  1  guard|sticky was set for this result.
- out_overflow  output  1  rounding/exponent produced Inf.
- flags_clr  input  1  clears sticky flags (only with FADD_STICKY_FLAGS_EN).
- sticky_flags  output  2  {overflow, inexact} accumulated (only with FADD_STICKY_FLAGS_EN).

## Operation
Stage S1 (round), loaded on an input handshake:
- Zero detect: m_in == 0 and exp_in == 0 → z = 1.
- lsb = m_in[1], g = m_in[0], s = round_in.
- inc = g & (s | lsb).
- frac_r = {1'b0, m_in[23:1]} + inc (FRAC_W+1 bits).
- Registered: sign, exp, frac_r, z, inexact = g|s.

Stage S2 (pack), loaded on S1→S2 advance:
- If z: result = 0x00000000. Sign is forced to 0; inexact = 0.
- Else if frac_r carry (bit FRAC_W) set: exp_n = exp + 1 and frac = 0.
- Otherwise: exp_n = exp and frac = frac_r[FRAC_W-1:0].
- exp_n is computed in EXP_W+1 bits.
- If exp_n ≥ 255 or exp == 255 on input: result = {sign, 8'hFF, 23'h0} and overflow = 1.
- Otherwise: result = {sign, exp_n[7:0], frac}.
- Denormals are not produced. exp_in == 0 with a nonzero mantissa is packed literally, with no gradual underflow.

Handshake:
- adv2 = !s2_valid | out_ready.
- adv1 = !s1_valid | adv2.
- in_ready = adv1, a combinational path from out_ready.
- Input transfer occurs on in_valid & in_ready.
- Output transfer occurs on out_valid & out_ready.
- While out_valid is high and out_ready is low, out_result and the flags hold stable and no data is lost or duplicated.

## Timing
- Latency: 2 cycles from input handshake to out_valid when unstalled.
- Throughput: 1 result per cycle.
- Reset (rst_n low, asynchronous): s1_valid = s2_valid = 0, out_valid = 0, out_result = 0, out_inexact = 0, out_overflow = 0, sticky_flags = 0.
- Reset mid-operation discards all in-flight data. in_ready is 1 on the first cycle after release.
- Full pipeline with out_ready low: in_ready = 0. Input handshake and output handshake in the same cycle are both honoured, and occupancy is unchanged.
- Empty pipeline: out_valid = 0. out_result keeps its last value, which is don't-care.

## Configuration
- FADD_STICKY_FLAGS_EN defined:
  - sticky_flags register ORs in {out_overflow, out_inexact} on every output handshake.
  - flags_clr clears it synchronously.
  - If a clear and a handshake occur in the same cycle, the register takes only the new handshake's flags.
- FADD_STICKY_FLAGS_EN undefined:
  - No register is built.
  - sticky_flags is tied to 0 and flags_clr is ignored.
  - All other behaviour is identical.

## Test plan
- Exact: sign 0, exp 0x7F, m_in 0x1000000, round 0 → 0x3F800000, inexact 0, after 2 cycles.
- Tie-to-even up: exp 0x7F, m_in 0x1000003, round 0 → 0x3F800002, inexact 1.
- Tie-to-even hold: m_in 0x1000001, round 0 → 0x3F800000, inexact 1. Same mantissa with round 1 → 0x3F800001.
- Carry: exp 0x7F, m_in 0x1FFFFFF → 0x40000000. With exp 0xFE → 0x7F800000, overflow 1.
- Zero: sign 1, m_in 0, exp 0 → 0x00000000, inexact 0.
- Backpressure:
  - Stimulus: 5 back-to-back inputs, out_ready low for cycles 3-6, then a mid-stream rst_n pulse.
  - Response: outputs in order with no loss or duplication; in_ready low while full; everything cleared by the reset.
  - Sticky flags (macro on): accumulate {1,1}; flags_clr returns them to 0.
